// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO between a UART receiver and a consumer.
// First-word fall-through output, explicit occupancy counter, synchronous flush.
// Optional macro UART_RX_FIFO_RTS_EN adds the rts_n output, driven by a
// two-state hysteresis FSM (READY/STOP) that throttles the remote sender.
//
// Handshakes:
//   upstream: a byte is pushed on every cycle where rx_rd=1. rx_rd is
//             rx_valid qualified by room (not full), no flush and reset
//             released; the receiver drops rx_valid the cycle after rx_rd.
//   consumer: valid=1 means data holds the oldest byte; a pop happens on
//             every cycle where rd & valid; rd while valid=0 is ignored.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_rd,
  input  logic                  rd,
  input  logic                  flush,
  output logic                  valid,
  output logic [7:0]            data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full
`ifdef UART_RX_FIFO_RTS_EN
  ,
  output logic                  rts_n
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_nxt;
  logic          push;
  logic          pop;

  // Status flags come straight from the occupancy register.
  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign data  = mem[rd_ptr];

  // Full refuses a byte even when a pop happens in the same cycle; the
  // byte is simply taken one cycle later.
  assign rx_rd = rx_valid & ~full & ~flush & resetq;
  assign push  = rx_rd;
  assign pop   = rd & valid;

  // Next occupancy; flush wins over any simultaneous push or pop.
  always_comb begin
    cnt_nxt = count;
    if (flush) begin
      cnt_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_nxt = count + CW'(1);
        2'b01:   cnt_nxt = count - CW'(1);
        default: cnt_nxt = count;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      count <= '0;
    end else begin
      count <= cnt_nxt;
    end
  end

  // Read and write pointers, wrapping naturally at the pointer width.
  always_ff @(posedge clk) begin
    if (!resetq || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is never cleared; push is already blocked during reset and flush.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

`ifdef UART_RX_FIFO_RTS_EN
  // rts_n is the state bit itself, so the FSM state is observable on the port.
  typedef enum logic {
    READY = 1'b0,
    STOP  = 1'b1
  } rts_state_t;

  localparam logic [CW-1:0] HI_MARK = CW'(DEPTH - 4);
  localparam logic [CW-1:0] LO_MARK = CW'(DEPTH / 2);

  rts_state_t state;
  rts_state_t state_nxt;

  // Flow-control state register.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      state <= READY;
    end else begin
      state <= state_nxt;
    end
  end

  // Hysteresis on the next-cycle occupancy; flush always releases the sender.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = READY;
    end else begin
      case (state)
        READY:   if (cnt_nxt >= HI_MARK) state_nxt = STOP;
        STOP:    if (cnt_nxt <= LO_MARK) state_nxt = READY;
        default: state_nxt = READY;
      endcase
    end
  end

  // Active-low ready-to-send: high only while stopped.
  always_comb begin
    rts_n = (state == STOP);
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo (DEPTH_LOG2=4).
// Table of per-cycle vectors for the basic push/pop behaviour, then
// hand-written sequences for full, simultaneous push/pop, flush, mid-fill
// reset and (with UART_RX_FIFO_RTS_EN) the rts_n hysteresis.
module tb_uart_rx_fifo;

  localparam int DL2 = 4;

  logic           clk;
  logic           resetq;
  logic           rx_valid;
  logic [7:0]     rx_data;
  logic           rx_rd;
  logic           rd;
  logic           flush;
  logic           valid;
  logic [7:0]     data;
  logic [DL2:0]   count;
  logic           full;
`ifdef UART_RX_FIFO_RTS_EN
  logic           rts_n;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk      (clk),
    .resetq   (resetq),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_rd    (rx_rd),
    .rd       (rd),
    .flush    (flush),
    .valid    (valid),
    .data     (data),
    .count    (count),
    .full     (full)
`ifdef UART_RX_FIFO_RTS_EN
    ,
    .rts_n    (rts_n)
`endif
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rv;
    logic [7:0] rdat;
    logic       r;
    logic       fl;
    logic       rs;
    logic       e_rxrd;
    logic       e_valid;
    logic [7:0] e_data;
    logic [4:0] e_count;
    logic       e_full;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, sample rx_rd before the edge, settle after it.
  task automatic cycle(input logic rv, input logic [7:0] rdat, input logic r,
                       input logic fl, input logic rs, output logic rxrd);
    rx_valid = rv;
    rx_data  = rdat;
    rd       = r;
    flush    = fl;
    resetq   = rs;
    #1 rxrd = rx_rd;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rd       = 1'b0;
    flush    = 1'b0;
    resetq   = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic s;
    cycle(1'b1, b, 1'b0, 1'b0, 1'b1, s);
    chk("push_rx_rd", 32'(s), 32'd1);
    exp_q.push_back(b);
  endtask

  task automatic pop_byte();
    logic s;
    chk("pop_valid", 32'(valid), 32'd1);
    if (exp_q.size() > 0) begin
      chk("pop_data", 32'(data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, s);
  endtask

  initial begin
    logic s;
    resetq   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rd       = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //          rv    rdat   r     fl    rs    rxrd  valid data   count full
    vecs[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 5'd1, 1'b0};
    vecs[2]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 5'd2, 1'b0};
    vecs[3]  = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 5'd3, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h41, 5'd3, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 5'd2, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h43, 5'd1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[9]  = '{1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 5'd1, 1'b0};
    vecs[10] = '{1'b1, 8'h9A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h9A, 5'd1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].rv, vecs[i].rdat, vecs[i].r, vecs[i].fl, vecs[i].rs, s);
      chk($sformatf("vec%0d_rx_rd", i), 32'(s), 32'(vecs[i].e_rxrd));
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      if (vecs[i].e_valid)
        chk($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].e_data));
    end
`ifdef UART_RX_FIFO_RTS_EN
    chk("table_rts_n", 32'(rts_n), 32'd0);
`endif

    // Fill to 16, then a waiting byte is held off until a pop makes room.
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, s);
    chk("full_rx_rd", 32'(s), 32'd0);
    chk("full_hold_count", 32'(count), 32'd16);
    chk("full_pop_data", 32'(data), 32'(exp_q[0]));
    void'(exp_q.pop_front());
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, s);
    chk("full_pop_rx_rd", 32'(s), 32'd0);
    chk("full_pop_count", 32'(count), 32'd15);
    push_byte(8'h55);
    chk("refill_count", 32'(count), 32'd16);
    chk("refill_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) pop_byte();
    chk("drain_valid", 32'(valid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // Simultaneous push and pop at count 5.
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    chk("sim_data_before", 32'(data), 32'h01);
    cycle(1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, s);
    chk("sim_rx_rd", 32'(s), 32'd1);
    chk("sim_count", 32'(count), 32'd5);
    chk("sim_data_after", 32'(data), 32'h02);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h7E);
    for (int i = 0; i < 5; i++) pop_byte();
    chk("sim_drain_valid", 32'(valid), 32'd0);

    // Flush at count 9 overrides push and pop.
    for (int i = 0; i < 9; i++) push_byte(8'hC0 + 8'(i));
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, s);
    chk("flush_rx_rd", 32'(s), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(valid), 32'd0);
    exp_q.delete();
    push_byte(8'hA5);
    pop_byte();
    chk("flush_after_valid", 32'(valid), 32'd0);

    // One-cycle reset at count 7 with a byte waiting upstream.
    for (int i = 0; i < 7; i++) push_byte(8'h20 + 8'(i));
    cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, s);
    chk("rst_rx_rd", 32'(s), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    exp_q.delete();
    push_byte(8'h3C);
    chk("rst_after_count", 32'(count), 32'd1);
    pop_byte();
    chk("rst_after_valid", 32'(valid), 32'd0);

`ifdef UART_RX_FIFO_RTS_EN
    // Hysteresis: stop at 12 going up, release at 8 going down.
    for (int n = 1; n <= 13; n++) begin
      push_byte(8'(n));
      chk($sformatf("rts_up_%0d", n), 32'(rts_n), (n >= 12) ? 32'd1 : 32'd0);
    end
    for (int n = 12; n >= 7; n--) begin
      pop_byte();
      chk($sformatf("rts_dn_%0d", n), 32'(rts_n), (n >= 9) ? 32'd1 : 32'd0);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, s);
    exp_q.delete();
    chk("rts_flush", 32'(rts_n), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
